// File: rtl/rep_acq_if.sv
// Host register port and capture-engine handshake for the repetition sequencer.
// The master is the host/engine side and the slave is the sequencer.
interface rep_acq_if #(
  parameter int ADDR_W = 32,
  parameter int SMP_W  = 8
);
  logic              cfg_we;
  logic [2:0]        cfg_addr;
  logic [31:0]       cfg_wdata;
  logic [31:0]       cfg_rdata;
  logic              cap_we_in;
  logic              cap_arm;
  logic [SMP_W-1:0]  cap_delay;
  logic [SMP_W-1:0]  cap_len;
  logic [ADDR_W-1:0] cap_base_addr;

  modport master (
    output cfg_we, cfg_addr, cfg_wdata, cap_we_in,
    input  cfg_rdata, cap_arm, cap_delay, cap_len, cap_base_addr
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_wdata, cap_we_in,
    output cfg_rdata, cap_arm, cap_delay, cap_len, cap_base_addr
  );
endinterface

// File: rtl/rep_acq_sequencer.sv
// Repetition-triggered acquisition controller: arms the capture engine once per
// repetition, steps the BRAM base address and reports completion/errors to the host.
module rep_acq_sequencer #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 'h40000000,
  parameter int                REP_W     = 24,
  parameter int                SMP_W     = 8,
  parameter int                TO_W      = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  rep_acq_if.slave bus,
  input  logic     ext_start,
  input  logic     trig,
  output logic     busy,
  output logic     done,
  output logic     irq
);
  typedef enum logic [2:0] {S_IDLE, S_ARM, S_WAIT_TRIG, S_CAPTURE, S_NEXT, S_DONE} state_t;

  state_t state_reg, state_next;

  logic [SMP_W-1:0]  delay_reg, len_reg, sh_delay_reg, sh_len_reg, wr_cnt_reg;
  logic [REP_W-1:0]  nrep_reg, sh_nrep_reg, rep_idx_reg, reps_done_reg;
  logic [ADDR_W-1:0] stride_reg, sh_stride_reg, base_reg;
  logic [TO_W-1:0]   timeout_reg, sh_timeout_reg, to_cnt_reg;
  logic              trig_d_reg, busy_reg, done_reg, cap_arm_reg, to_hit_reg;
  logic              done_sticky_reg, timeout_err_reg, cfg_err_reg, aborted_reg, overrun_reg;
  logic [31:0]       rdata_reg, rdata_next;

  logic ctrl_wr, start_go, abort_go, cfg_ok, trig_edge, timeout_hit, len_reached, last_rep;

  always_comb begin
    ctrl_wr     = bus.cfg_we && (bus.cfg_addr == 3'd0);
    abort_go    = ctrl_wr && bus.cfg_wdata[1];
    // Abort beats a simultaneous start, even from IDLE.
    start_go    = ((ctrl_wr && bus.cfg_wdata[0]) || ext_start) && !abort_go;
    cfg_ok      = (nrep_reg != '0) && (len_reg != '0);
    trig_edge   = trig && !trig_d_reg;
    timeout_hit = (sh_timeout_reg != '0) && (to_cnt_reg == sh_timeout_reg - TO_W'(1));
    // The write that brings the count to LEN ends the repetition in the same cycle.
    len_reached = bus.cap_we_in && (wr_cnt_reg + SMP_W'(1) == sh_len_reg);
    last_rep    = (rep_idx_reg + REP_W'(1) == sh_nrep_reg);
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      S_IDLE:      if (start_go && cfg_ok) state_next = S_ARM;
      S_ARM:       state_next = S_WAIT_TRIG;
      S_WAIT_TRIG: if (timeout_hit) state_next = S_DONE;
                   else if (trig_edge) state_next = S_CAPTURE;
      S_CAPTURE:   if (timeout_hit) state_next = S_DONE;
                   else if (len_reached) state_next = S_NEXT;
      S_NEXT:      state_next = last_rep ? S_DONE : S_ARM;
      S_DONE:      state_next = S_IDLE;
      default:     state_next = S_IDLE;
    endcase
    if (abort_go && state_reg != S_IDLE) state_next = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= S_IDLE;
      delay_reg       <= '0;
      len_reg         <= '0;
      nrep_reg        <= '0;
      stride_reg      <= '0;
      timeout_reg     <= '0;
      sh_delay_reg    <= '0;
      sh_len_reg      <= '0;
      sh_nrep_reg     <= '0;
      sh_stride_reg   <= '0;
      sh_timeout_reg  <= '0;
      wr_cnt_reg      <= '0;
      rep_idx_reg     <= '0;
      reps_done_reg   <= '0;
      base_reg        <= BASE_ADDR;
      to_cnt_reg      <= '0;
      trig_d_reg      <= 1'b0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
      cap_arm_reg     <= 1'b0;
      to_hit_reg      <= 1'b0;
      done_sticky_reg <= 1'b0;
      timeout_err_reg <= 1'b0;
      cfg_err_reg     <= 1'b0;
      aborted_reg     <= 1'b0;
      overrun_reg     <= 1'b0;
    end else begin
      state_reg  <= state_next;
      trig_d_reg <= trig;
      done_reg   <= 1'b0;

      if (bus.cfg_we) begin
        unique case (bus.cfg_addr)
          3'd1:    delay_reg   <= bus.cfg_wdata[SMP_W-1:0];
          3'd2:    len_reg     <= bus.cfg_wdata[SMP_W-1:0];
          3'd3:    nrep_reg    <= bus.cfg_wdata[REP_W-1:0];
          3'd4:    stride_reg  <= bus.cfg_wdata[ADDR_W-1:0];
          3'd5:    timeout_reg <= bus.cfg_wdata[TO_W-1:0];
          3'd6: begin
            if (bus.cfg_wdata[1]) done_sticky_reg <= 1'b0;
            if (bus.cfg_wdata[2]) timeout_err_reg <= 1'b0;
            if (bus.cfg_wdata[3]) cfg_err_reg     <= 1'b0;
            if (bus.cfg_wdata[4]) aborted_reg     <= 1'b0;
            if (bus.cfg_wdata[5]) overrun_reg     <= 1'b0;
          end
          default: ;
        endcase
      end

      // Sticky sets below are placed after the clears so a same-cycle event wins.
      if (trig_edge && state_reg == S_CAPTURE) overrun_reg <= 1'b1;

      if (abort_go && state_reg != S_IDLE) begin
        cap_arm_reg <= 1'b0;
        busy_reg    <= 1'b0;
        aborted_reg <= 1'b1;
      end else begin
        unique case (state_reg)
          S_IDLE: if (start_go) begin
            if (cfg_ok) begin
              sh_delay_reg   <= delay_reg;
              sh_len_reg     <= len_reg;
              sh_nrep_reg    <= nrep_reg;
              sh_stride_reg  <= stride_reg;
              sh_timeout_reg <= timeout_reg;
              rep_idx_reg    <= '0;
              reps_done_reg  <= '0;
              base_reg       <= BASE_ADDR;
              busy_reg       <= 1'b1;
              to_hit_reg     <= 1'b0;
            end else begin
              cfg_err_reg <= 1'b1;
            end
          end
          S_ARM: begin
            cap_arm_reg <= 1'b1;
            to_cnt_reg  <= '0;
            wr_cnt_reg  <= '0;
          end
          S_WAIT_TRIG, S_CAPTURE: begin
            to_cnt_reg <= to_cnt_reg + TO_W'(1);
            if (state_reg == S_CAPTURE && bus.cap_we_in) wr_cnt_reg <= wr_cnt_reg + SMP_W'(1);
            if (timeout_hit) begin
              timeout_err_reg <= 1'b1;
              to_hit_reg      <= 1'b1;
              cap_arm_reg     <= 1'b0;
            end else if (state_reg == S_WAIT_TRIG && trig_edge) begin
              cap_arm_reg <= 1'b0;
            end
          end
          S_NEXT: begin
            reps_done_reg <= reps_done_reg + REP_W'(1);
            rep_idx_reg   <= rep_idx_reg + REP_W'(1);
            base_reg      <= base_reg + sh_stride_reg;
          end
          S_DONE: begin
            busy_reg    <= 1'b0;
            cap_arm_reg <= 1'b0;
            if (!to_hit_reg) begin
              done_reg        <= 1'b1;
              done_sticky_reg <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    rdata_next = '0;
    unique case (bus.cfg_addr)
      3'd1:    rdata_next = 32'(delay_reg);
      3'd2:    rdata_next = 32'(len_reg);
      3'd3:    rdata_next = 32'(nrep_reg);
      3'd4:    rdata_next = 32'(stride_reg);
      3'd5:    rdata_next = 32'(timeout_reg);
      3'd6:    rdata_next = 32'({overrun_reg, aborted_reg, cfg_err_reg,
                                 timeout_err_reg, done_sticky_reg, busy_reg});
      3'd7:    rdata_next = 32'(reps_done_reg);
      default: rdata_next = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_reg <= '0;
    else        rdata_reg <= rdata_next;
  end

  assign bus.cfg_rdata     = rdata_reg;
  assign bus.cap_arm       = cap_arm_reg;
  assign bus.cap_delay     = sh_delay_reg;
  assign bus.cap_len       = sh_len_reg;
  assign bus.cap_base_addr = base_reg;
  assign busy              = busy_reg;
  assign done              = done_reg;
  assign irq               = done_sticky_reg | timeout_err_reg | cfg_err_reg;
endmodule

// File: doc/rep_acq_sequencer.md
Name: rep_acq_sequencer

Overview:
- Controller for the repetition-triggered capture datapath.
- Holds host-programmed acquisition settings (pre-trigger delay, samples per repetition, repetition count, address stride, timeout).
- Arms the capture engine once per repetition and hands it a per-repetition BRAM base address.
- Counts completed writes, and reports done, error and status to the host through a small register port.

Parameters:
ADDR_W, 32, width of capture write addresses
BASE_ADDR, 32'h40000000, BRAM base address of repetition 0
REP_W, 24, width of repetition count and index
SMP_W, 8, width of delay and length fields
TO_W, 32, width of timeout counter

Ports:
clk  in  1  system clock (ADC clock domain)
rst_n  in  1  asynchronous active-low reset
cfg_we  in  1  register write strobe
cfg_addr  in  3  register index
cfg_wdata  in  32  register write data
cfg_rdata  out  32  register read data, registered, 1-cycle latency from cfg_addr
ext_start  in  1  start pulse from trigger-sniffer logic
trig  in  1  raw repetition trigger, synchronous to clk
cap_we_in  in  1  write_enable monitored from capture engine
cap_arm  out  1  level; capture engine armed for one repetition
cap_delay  out  SMP_W  pre-trigger sample delay for engine
cap_len  out  SMP_W  samples per repetition for engine
cap_base_addr  out  ADDR_W  write base for current repetition
busy  out  1  sequence running
done  out  1  one-cycle pulse on normal completion
irq  out  1  level; set on done or error, cleared by host

Behaviour:
- Reset: all outputs 0; cap_base_addr=BASE_ADDR; FSM=IDLE; all config registers 0; sticky bits clear.
- Registers:
  - 0 CTRL (w): bit0 start (self-clearing), bit1 abort.
  - 1 DELAY[SMP_W-1:0].
  - 2 LEN[SMP_W-1:0].
  - 3 NREP[REP_W-1:0].
  - 4 STRIDE[ADDR_W-1:0].
  - 5 TIMEOUT[TO_W-1:0]; 0 = disabled.
  - 6 STATUS (r): bit0 busy, bit1 done_sticky, bit2 timeout_err, bit3 cfg_err, bit4 aborted, bit5 trig_overrun. Write 1 to bits1-5 clears them; irq deasserts when bits1-3 are all clear.
  - 7 REPS_DONE (r).
- Config writes are always accepted. Running sequences use shadow copies latched at start.
- Start = CTRL bit0 write, or ext_start high. Ignored while busy.
- trig edge: trig_d is trig registered; edge = trig & ~trig_d.
- States:
  - IDLE: on start with NREP!=0 and LEN!=0: latch shadows, rep_idx=0, REPS_DONE=0, cap_base_addr=BASE_ADDR, busy=1, go ARM. On start with NREP==0 or LEN==0: set cfg_err and irq, stay IDLE.
  - ARM: cap_arm<=1, clear timeout counter and write counter, go WAIT_TRIG.
  - WAIT_TRIG: timeout counter increments each cycle. On edge, go CAPTURE. If TIMEOUT!=0 and counter==TIMEOUT-1, set timeout_err and go DONE.
  - CAPTURE: cap_arm<=0 on entry. Each cycle cap_we_in=1 increments the write counter. When the write counter reaches LEN, go NEXT. Timeout counter keeps running and is not cleared at the edge; same timeout rule applies. An edge in CAPTURE is not queued; it sets trig_overrun.
  - NEXT (1 cycle): REPS_DONE++, rep_idx++, cap_base_addr <= cap_base_addr + STRIDE (mod 2^ADDR_W, wraps silently). If rep_idx+1==NREP go DONE, else go ARM.
  - DONE (1 cycle): on normal completion done=1 and done_sticky=1. Either way irq=1, busy<=0, cap_arm=0, go IDLE.
- Latency: edge→CAPTURE 1 cycle. Last write→busy low 3 cycles (CAPTURE detect, NEXT, DONE).
- Abort in any non-IDLE state: next cycle IDLE, cap_arm=0, busy=0, aborted=1, no done pulse, irq unchanged, REPS_DONE retains its count.
- Abort and start in the same cycle: abort wins; from IDLE nothing happens and aborted is not set.
- Reset mid-sequence: immediate return to reset values; no done pulse.
- cap_delay and cap_len drive the shadow values, held stable while busy.

Test Plan:
- DELAY=5, LEN=7, NREP=2, STRIDE=8, start; two trig edges, engine asserts cap_we_in 7 cycles each → cap_base_addr 0x40000000 then 0x40000008; REPS_DONE=2; single done pulse 3 cycles after last write; irq=1.
- NREP=0, start → cfg_err=1, irq=1, busy stays 0, cap_arm never asserted.
- TIMEOUT=100, NREP=1, no trig → timeout_err at cycle 100 after ARM; busy falls; done stays 0.
- Abort written during CAPTURE of rep 1 of 3 → IDLE next cycle; aborted=1; REPS_DONE=1; cap_arm=0; no done pulse.
- Extra trig edge during CAPTURE → trig_overrun=1; the sequence completes normally with the correct REPS_DONE.
- STRIDE=0x40000000, NREP=4 → addresses 0x40000000, 0x80000000, 0xC0000000, then wrap to 0x00000000; STATUS write 0x3E clears all sticky bits and irq.
